// File: rtl/i_cache_if.sv
// Fetch/memory-side bus of the instruction cache: lookup address, branch task,
// allocate and fill requests in; two-block lookup result out.
interface i_cache_if;
  logic [31:0]      proc2Icache_addr;
  logic [1:0]       br_task;
  logic [31:0]      alloc_addr;
  logic             alloc_en;
  logic             write_en;
  logic [31:0]      write_addr;
  logic [63:0]      write_data;
  logic [1:0][63:0] Icache_data_out;
  logic [1:0]       Icache_valid_out;
  logic [1:0]       Icache_alloc_out;

  modport master (
    output proc2Icache_addr, br_task, alloc_addr, alloc_en,
           write_en, write_addr, write_data,
    input  Icache_data_out, Icache_valid_out, Icache_alloc_out
  );

  modport slave (
    input  proc2Icache_addr, br_task, alloc_addr, alloc_en,
           write_en, write_addr, write_data,
    output Icache_data_out, Icache_valid_out, Icache_alloc_out
  );
endinterface

// File: rtl/i_cache.sv
// Direct-mapped instruction cache: combinational lookup of the fetch block and
// its successor, allocate on miss issue, fill on memory return, squash drops allocs.
module i_cache #(
  parameter int NUM_LINES = 32,
  parameter int IDX_BITS  = $clog2(NUM_LINES)
) (
  input logic      clock,
  input logic      reset,
  i_cache_if.slave bus
);
  localparam int         TAG_BITS  = 32 - 3 - IDX_BITS;
  localparam logic [1:0] BR_SQUASH = 2'd2;

  logic [TAG_BITS-1:0]  line_tag  [NUM_LINES];
  logic [63:0]          line_data [NUM_LINES];
  logic [NUM_LINES-1:0] line_valid;
  logic [NUM_LINES-1:0] line_alloc;

  logic [31:0]         blk_addr [2];
  logic [IDX_BITS-1:0] fill_idx, alloc_idx;
  logic [TAG_BITS-1:0] fill_tag, alloc_tag;

  assign blk_addr[0] = bus.proc2Icache_addr & ~32'h7;
  // Wraps modulo 2^32, so the index naturally rolls over to (idx0 + 1) mod NUM_LINES.
  assign blk_addr[1] = blk_addr[0] + 32'd8;

  assign fill_idx  = IDX_BITS'(bus.write_addr >> 3);
  assign fill_tag  = TAG_BITS'(bus.write_addr >> (3 + IDX_BITS));
  assign alloc_idx = IDX_BITS'(bus.alloc_addr >> 3);
  assign alloc_tag = TAG_BITS'(bus.alloc_addr >> (3 + IDX_BITS));

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [IDX_BITS-1:0] idx;
    logic [TAG_BITS-1:0] tag;
    logic                tag_match;
    logic                hit;

    assign idx       = IDX_BITS'(blk_addr[p] >> 3);
    assign tag       = TAG_BITS'(blk_addr[p] >> (3 + IDX_BITS));
    assign tag_match = (line_tag[idx] == tag);
    assign hit       = line_valid[idx] & tag_match;

    assign bus.Icache_valid_out[p] = hit;
    assign bus.Icache_alloc_out[p] = line_alloc[idx] & tag_match;
    assign bus.Icache_data_out[p]  = hit ? line_data[idx] : 64'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: tags and data are cleared too, not just the status bits, so a
      // reset cache is indistinguishable from a power-on-zero one.
      for (int i = 0; i < NUM_LINES; i++) begin
        line_tag[i]  <= '0;
        line_data[i] <= '0;
      end
      line_valid <= '0;
      line_alloc <= '0;
    end else begin
      // NOTE: priority squash < fill < allocate comes from statement order:
      // the last non-blocking assignment to a bit in this block wins.
      if (bus.br_task == BR_SQUASH) begin
        line_alloc <= '0;
      end
      if (bus.write_en) begin
        line_tag[fill_idx]   <= fill_tag;
        line_data[fill_idx]  <= bus.write_data;
        line_valid[fill_idx] <= 1'b1;
        line_alloc[fill_idx] <= 1'b0;
      end
      if (bus.alloc_en) begin
        line_tag[alloc_idx]   <= alloc_tag;
        line_valid[alloc_idx] <= 1'b0;
        line_alloc[alloc_idx] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_i_cache.sv
// Bench for i_cache: directed scenarios followed by random allocate/fill/squash
// traffic, all lookups compared against a block-address-level reference model.
module tb_i_cache;
  localparam int         NL        = 32;
  localparam logic [1:0] BR_NONE   = 2'd0;
  localparam logic [1:0] BR_SQUASH = 2'd2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad   = 0;

  i_cache_if bus();

  i_cache #(.NUM_LINES(NL)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Model line: remembers the full block address it holds; the tag match is
  // simply "same block address" since the index is already implied.
  typedef struct {
    bit          v;
    bit          a;
    logic [31:0] blk;
    logic [63:0] d;
  } line_t;

  line_t m [NL];

  function automatic int line_of(input logic [31:0] addr);
    return int'((addr >> 3) % NL);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m[i].v   = 1'b0;
      m[i].a   = 1'b0;
      m[i].blk = 32'h0;
      m[i].d   = 64'h0;
    end
  endtask

  task automatic model_edge(input bit sq, input bit we, input logic [31:0] wa,
                            input logic [63:0] wd, input bit ae, input logic [31:0] aa);
    int li;
    if (sq) for (int i = 0; i < NL; i++) m[i].a = 1'b0;
    if (we) begin
      li       = line_of(wa);
      m[li].blk = wa & ~32'h7;
      m[li].d   = wd;
      m[li].v   = 1'b1;
      m[li].a   = 1'b0;
    end
    if (ae) begin
      li       = line_of(aa);
      m[li].blk = aa & ~32'h7;
      m[li].v   = 1'b0;
      m[li].a   = 1'b1;
    end
  endtask

  task automatic idle_inputs();
    bus.alloc_en   = 1'b0;
    bus.alloc_addr = 32'h0;
    bus.write_en   = 1'b0;
    bus.write_addr = 32'h0;
    bus.write_data = 64'h0;
    bus.br_task    = BR_NONE;
  endtask

  // Drive one cycle of requests, let the edge capture them, update the model.
  task automatic cycle(input bit ae, input logic [31:0] aa, input bit we,
                       input logic [31:0] wa, input logic [63:0] wd, input bit sq);
    bus.alloc_en   = ae;
    bus.alloc_addr = aa;
    bus.write_en   = we;
    bus.write_addr = wa;
    bus.write_data = wd;
    bus.br_task    = sq ? BR_SQUASH : BR_NONE;
    @(posedge clock);
    model_edge(sq, we, wa, wd, ae, aa);
    #1;
    idle_inputs();
  endtask

  task automatic check(input string name, input logic [31:0] addr);
    logic [1:0]       ev, ea;
    logic [1:0][63:0] ed;
    logic [31:0]      blk;
    int               li;
    for (int p = 0; p < 2; p++) begin
      blk   = (addr & ~32'h7) + 32'(p * 8);
      li    = line_of(blk);
      ev[p] = m[li].v && (m[li].blk == blk);
      ea[p] = m[li].a && (m[li].blk == blk);
      ed[p] = ev[p] ? m[li].d : 64'h0;
    end
    bus.proc2Icache_addr = addr;
    #1;
    total++;
    assert (bus.Icache_valid_out === ev) else begin
      bad++;
      $error("FAIL %s valid addr=%h observed=%b expected=%b", name, addr, bus.Icache_valid_out, ev);
    end
    total++;
    assert (bus.Icache_alloc_out === ea) else begin
      bad++;
      $error("FAIL %s alloc addr=%h observed=%b expected=%b", name, addr, bus.Icache_alloc_out, ea);
    end
    total++;
    assert (bus.Icache_data_out === ed) else begin
      bad++;
      $error("FAIL %s data addr=%h observed=%h expected=%h", name, addr, bus.Icache_data_out, ed);
    end
  endtask

  initial begin
    bit          ae, we, sq;
    logic [31:0] aa, wa;
    logic [63:0] wd;

    idle_inputs();
    bus.proc2Icache_addr = 32'h0;
    model_reset();

    // Reset held: everything reads as zero.
    #2;
    check("rst_hold", 32'h0000_0000);
    reset = 1'b1;

    // Allocate then fill one line; same line seen on port [1] from 0x0FC.
    cycle(1'b1, 32'h100, 1'b0, 32'h0, 64'h0, 1'b0);
    check("alloc_100", 32'h100);
    cycle(1'b0, 32'h0, 1'b1, 32'h100, 64'hDEAD_BEEF_0123_4567, 1'b0);
    check("fill_100", 32'h100);
    check("fill_100_port1", 32'h0FC);

    // Index conflict, then two adjacent blocks from one lookup.
    cycle(1'b0, 32'h0, 1'b1, 32'h200, 64'h1111_2222_3333_4444, 1'b0);
    check("conflict_old", 32'h100);
    check("conflict_new", 32'h200);
    cycle(1'b0, 32'h0, 1'b1, 32'h208, 64'h5555_6666_7777_8888, 1'b0);
    check("pair_204", 32'h204);

    // Squash after an allocate, and allocate in the squash cycle.
    cycle(1'b1, 32'h300, 1'b0, 32'h0, 64'h0, 1'b0);
    check("alloc_300", 32'h300);
    cycle(1'b0, 32'h0, 1'b0, 32'h0, 64'h0, 1'b1);
    check("squash_300", 32'h300);
    check("squash_keep_208", 32'h208);
    cycle(1'b1, 32'h300, 1'b0, 32'h0, 64'h0, 1'b1);
    check("alloc_in_squash", 32'h300);

    // Same-cycle fill and allocate at one index: allocate wins.
    cycle(1'b1, 32'h800, 1'b1, 32'h400, 64'hCAFE_F00D_0000_0400, 1'b0);
    check("fa_alloc_800", 32'h800);
    check("fa_fill_400", 32'h400);

    // Lookup at the top of the address space wraps A1 to block 0.
    cycle(1'b0, 32'h0, 1'b1, 32'h0, 64'h0BAD_0000_0000_0000, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 64'hFFFF_0000_FFFF_0000, 1'b0);
    check("wrap_top", 32'hFFFF_FFF8);

    // Asynchronous reset mid-cycle clears outputs before the next edge.
    cycle(1'b0, 32'h0, 1'b1, 32'h108, 64'h0123_0123_0123_0123, 1'b0);
    reset = 1'b0;
    model_reset();
    check("rst_async", 32'h100);
    reset = 1'b1;
    cycle(1'b0, 32'h0, 1'b1, 32'h100, 64'hABCD_ABCD_ABCD_ABCD, 1'b0);
    check("after_rst", 32'h0FC);

    // Random traffic over 96 blocks (three tags per index).
    for (int n = 0; n < 400; n++) begin
      ae = ($urandom_range(0, 2) == 0);
      we = ($urandom_range(0, 1) == 0);
      sq = ($urandom_range(0, 9) == 0);
      aa = 32'($urandom_range(0, 95)) * 32'd8 + 32'($urandom_range(0, 7));
      wa = 32'($urandom_range(0, 95)) * 32'd8 + 32'($urandom_range(0, 7));
      wd = {$urandom, $urandom};
      cycle(ae, aa, we, wa, wd, sq);
      check("random", 32'($urandom_range(0, 95)) * 32'd8 + 32'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i_cache.md
# i_cache

Direct-mapped, two-port-read instruction cache between the fetch stage and the memory MSHR logic. Each cycle it combinationally presents the 8-byte block containing the fetch address and the following block, with hit and pending-miss status for each. Fetch allocates a line when it issues a memory request, and writes the line when memory returns. A branch squash cancels outstanding allocations.

## Interface
- NUM_LINES, default 32: number of lines, power of two ≥ 2; each line holds one 64-bit MEM_BLOCK.
- IDX_BITS, default $clog2(NUM_LINES): index width; index = addr[3+IDX_BITS-1:3], tag = addr[31:3+IDX_BITS].
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- proc2Icache_addr  in  32 (ADDR)  fetch address; the low 3 bits are ignored for lookup.
- br_task  in  BR_TASK  branch task; only SQUASH is acted on.
- alloc_addr  in  32 (ADDR)  block address of a newly issued memory request.
- alloc_en  in  1  allocate the line for alloc_addr this cycle.
- write_en  in  1  fill data from memory this cycle.
- write_addr  in  32 (ADDR)  block address of the fill.
- write_data  in  64 (MEM_BLOCK)  fill data.
- Icache_data_out  out  2×64 (MEM_BLOCK [1:0])  [0] is the block at A0 = {addr[31:3],3'b0}; [1] is the block at A1 = A0+8.
- Icache_valid_out  out  2  per block: hit.
- Icache_alloc_out  out  2  per block: a request is outstanding and the data has not arrived.

## Operation
- Per-line state: tag, valid bit, alloc bit, 64-bit data.
- Lookup is purely combinational from the registered state, separately for A0 and A1.
  - A1 wraps modulo 2^32. Its index is (index(A0)+1) mod NUM_LINES.
  - Icache_valid_out[i] = line.valid & (line.tag == tag(Ai)).
  - Icache_alloc_out[i] = line.alloc & (line.tag == tag(Ai)).
  - Icache_data_out[i] = line data when Icache_valid_out[i] is 1, otherwise 64'b0.
- Allocate (alloc_en=1): at line index(alloc_addr), set tag = tag(alloc_addr), valid = 0, alloc = 1. Data is unchanged.
- Fill (write_en=1): at line index(write_addr), set tag = tag(write_addr), data = write_data, valid = 1, alloc = 0. The fill installs unconditionally; no check against the pending tag is made.
- Squash (br_task == SQUASH): clear every alloc bit. Valid lines, tags and data are retained.
- Simultaneous events, applied in this order at the clock edge (later steps override earlier ones):
  1. Squash.
  2. Fill.
  3. Allocate.
  - So an allocate to the same index as a fill in the same cycle leaves that line allocated and invalid.
  - An allocate in the squash cycle survives the squash.
- No bypass: a fill or allocate becomes visible on the outputs only in the cycle after the edge that captures it.
- A0 and A1 may map to the same line only when NUM_LINES = 1, which is disallowed.

## Timing
- Read latency is 0 cycles (combinational). Write and allocate latency is 1 cycle.
- Reset (reset=0, asynchronous): all valid and alloc bits = 0, all tags and data = 0.
  - Outputs immediately show Icache_valid_out = 2'b00, Icache_alloc_out = 2'b00 and Icache_data_out = 0, and hold those values while reset is asserted.
- Assertion mid-operation discards all lines and pending allocations. The first edge after deassertion applies inputs normally.
- There is no handshake and no stall: the block accepts one allocate and one fill in every cycle.

## Test plan
- Reset then read addr 0x0000_0000 -> valid = 00, alloc = 00, data = 0. Asserting reset asynchronously mid-cycle after fills -> outputs drop to zero before the next edge.
- Allocate 0x100 (alloc_en=1), then read at 0x100 -> alloc = 01, valid = 00. Then fill 0x100 with 64'hDEAD_BEEF_0123_4567 -> the next cycle shows valid = 01, alloc = 00 and data[0] = that value. A read at 0x0FC gives the same line on port [1]: valid = 10.
- Fill 0x200 and 0x208, read addr 0x204 -> valid = 11, data[0] = block 0x200, data[1] = block 0x208.
- Conflict: fill 0x100 with NUM_LINES = 32, then fill 0x200 (same index) -> a read at 0x100 gives valid = 00 and a read at 0x200 gives valid = 01.
- Allocate 0x300, squash next cycle -> alloc = 00 afterwards while previously filled lines stay valid. Allocate and SQUASH in the same cycle -> alloc = 01.
- Same-cycle fill 0x400 and allocate 0x800 (same index) -> line is allocated with tag of 0x800: a read at 0x800 gives alloc = 01, a read at 0x400 gives valid = 00. Read at 0xFFFF_FFF8 -> A1 wraps to 0x0 with index 0.
